// File: rtl/rename_rat.sv
// Register rename: speculative RAT plus retirement RAT, one instruction per cycle.
// Sources read the RAT before the destination update, so no intra-instruction bypass is needed.
module rename_rat #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ARCH_REGS     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rs1_a,
  input  logic [4:0]               in_rs2_a,
  input  logic [4:0]               in_rd_a,
  input  logic                     in_rd_we,
  input  logic                     fl_avail,
  input  logic [PHYS_REG_BITS-1:0] fl_head,
  output logic                     fl_pop,
  output logic                     out_valid,
  input  logic                     out_stall,
  output logic [PHYS_REG_BITS-1:0] out_rs1_p,
  output logic [PHYS_REG_BITS-1:0] out_rs2_p,
  output logic [PHYS_REG_BITS-1:0] out_rd_p,
  output logic [PHYS_REG_BITS-1:0] out_old_rd_p,
  output logic                     out_rd_we,
  input  logic                     commit_valid,
  input  logic [4:0]               commit_rd_a,
  input  logic [PHYS_REG_BITS-1:0] commit_rd_p,
  output logic                     free_push,
  output logic [PHYS_REG_BITS-1:0] free_data,
  input  logic                     flush
);

  typedef logic [PHYS_REG_BITS-1:0] ptag_t;

  ptag_t rat  [ARCH_REGS];
  ptag_t rrat [ARCH_REGS];

  logic fire;
  logic alloc;
  logic commit_en;

  assign in_ready  = ~rst & ~flush & (~out_valid | ~out_stall) &
                     (fl_avail | ~in_rd_we | (in_rd_a == 5'd0));
  assign fire      = in_valid & in_ready;
  assign alloc     = fire & in_rd_we & (in_rd_a != 5'd0);
  assign fl_pop    = alloc;
  assign commit_en = ~rst & commit_valid & (commit_rd_a != 5'd0);
  assign free_push = commit_en;
  assign free_data = rrat[commit_rd_a];

  // Entry 0 is never written, so x0 stays mapped to tag 0 in both tables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rrat[i] <= PHYS_REG_BITS'(i);
    end else if (commit_en) begin
      rrat[commit_rd_a] <= commit_rd_p;
    end
  end

  // Flush restores from the post-commit RRAT so a same-cycle commit is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PHYS_REG_BITS'(i);
    end else if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= (commit_en && (commit_rd_a == 5'(i))) ? commit_rd_p : rrat[i];
      end
    end else if (alloc) begin
      rat[in_rd_a] <= fl_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_rs1_p    <= '0;
      out_rs2_p    <= '0;
      out_rd_p     <= '0;
      out_old_rd_p <= '0;
      out_rd_we    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_rs1_p    <= rat[in_rs1_a];
      out_rs2_p    <= rat[in_rs2_a];
      out_rd_p     <= alloc ? fl_head : '0;
      out_old_rd_p <= alloc ? rat[in_rd_a] : '0;
      out_rd_we    <= alloc;
    end else if (~out_stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_rat.sv
// Bench for rename_rat: directed scenarios then random traffic against a table-level model.
module tb_rename_rat;
  localparam int PB = 6;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_rd_we;
  logic [4:0] in_rs1_a, in_rs2_a, in_rd_a;
  logic fl_avail, fl_pop;
  logic [PB-1:0] fl_head;
  logic out_valid, out_stall, out_rd_we;
  logic [PB-1:0] out_rs1_p, out_rs2_p, out_rd_p, out_old_rd_p;
  logic commit_valid;
  logic [4:0] commit_rd_a;
  logic [PB-1:0] commit_rd_p;
  logic free_push;
  logic [PB-1:0] free_data;
  logic flush;

  always #5 clk = ~clk;

  rename_rat #(.PHYS_REG_BITS(PB), .ARCH_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_a(in_rs1_a), .in_rs2_a(in_rs2_a), .in_rd_a(in_rd_a), .in_rd_we(in_rd_we),
    .fl_avail(fl_avail), .fl_head(fl_head), .fl_pop(fl_pop),
    .out_valid(out_valid), .out_stall(out_stall),
    .out_rs1_p(out_rs1_p), .out_rs2_p(out_rs2_p), .out_rd_p(out_rd_p),
    .out_old_rd_p(out_old_rd_p), .out_rd_we(out_rd_we),
    .commit_valid(commit_valid), .commit_rd_a(commit_rd_a), .commit_rd_p(commit_rd_p),
    .free_push(free_push), .free_data(free_data), .flush(flush)
  );

  typedef struct {
    logic [4:0]    a;
    logic [PB-1:0] p;
  } ent_t;

  // Reference state: architectural maps as plain arrays, free list and in-flight renames as queues.
  logic [PB-1:0] m_rat [32];
  logic [PB-1:0] m_rrat[32];
  logic          m_ov, m_we;
  logic [PB-1:0] m_rs1, m_rs2, m_rd, m_old;
  logic [PB-1:0] fl_q[$];
  ent_t          cq[$];
  logic          fl_block;

  int n_chk  = 0;
  int n_pass = 0;
  logic          obs_ready, obs_pop, obs_push;
  logic [PB-1:0] obs_fdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rat[i]  = PB'(i);
      m_rrat[i] = PB'(i);
    end
    m_ov = 1'b0; m_we = 1'b0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_old = '0;
    fl_q.delete();
    for (int t = 32; t < (1 << PB); t++) fl_q.push_back(PB'(t));
    cq.delete();
  endtask

  task automatic put_front(input logic [PB-1:0] tag);
    for (int k = 0; k < fl_q.size(); k++) begin
      if (fl_q[k] == tag) begin
        fl_q.delete(k);
        break;
      end
    end
    fl_q.push_front(tag);
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; in_rd_we = 1'b0;
    in_rs1_a = '0; in_rs2_a = '0; in_rd_a = '0;
    commit_valid = 1'b0; commit_rd_a = '0; commit_rd_p = '0;
    flush = 1'b0; out_stall = 1'b0; fl_block = 1'b0;
  endtask

  task automatic ren(input int rs1, input int rs2, input int rd, input logic we);
    in_valid = 1'b1;
    in_rs1_a = 5'(rs1); in_rs2_a = 5'(rs2); in_rd_a = 5'(rd); in_rd_we = we;
  endtask

  task automatic commit_head();
    if (cq.size() > 0) begin
      commit_valid = 1'b1;
      commit_rd_a  = cq[0].a;
      commit_rd_p  = cq[0].p;
    end
  endtask

  task automatic step();
    logic          e_ready, e_fire, e_alloc, e_push;
    logic [PB-1:0] e_fdata;
    logic [PB-1:0] nrrat[32];
    fl_avail = (fl_q.size() > 0) && !fl_block;
    fl_head  = (fl_q.size() > 0) ? fl_q[0] : '0;
    @(negedge clk);
    e_ready = !rst && !flush && (!m_ov || !out_stall) &&
              (fl_avail || !in_rd_we || in_rd_a == 5'd0);
    e_fire  = in_valid && e_ready;
    e_alloc = e_fire && in_rd_we && in_rd_a != 5'd0;
    e_push  = !rst && commit_valid && commit_rd_a != 5'd0;
    e_fdata = m_rrat[commit_rd_a];
    obs_ready = in_ready; obs_pop = fl_pop; obs_push = free_push; obs_fdata = free_data;
    check("in_ready", in_ready, e_ready);
    check("fl_pop", fl_pop, e_alloc);
    check("free_push", free_push, e_push);
    if (e_push) check("free_data", free_data, e_fdata);
    if (rst) begin
      model_reset();
    end else begin
      nrrat = m_rrat;
      if (e_push) begin
        fl_q.push_back(e_fdata);
        nrrat[commit_rd_a] = commit_rd_p;
        void'(cq.pop_front());
      end
      if (flush) begin
        m_rat = nrrat;
        m_ov  = 1'b0;
        foreach (cq[k]) fl_q.push_back(cq[k].p);
        cq.delete();
      end else if (e_fire) begin
        m_rs1 = m_rat[in_rs1_a];
        m_rs2 = m_rat[in_rs2_a];
        if (e_alloc) begin
          m_rd  = fl_head;
          m_old = m_rat[in_rd_a];
          m_we  = 1'b1;
          m_rat[in_rd_a] = fl_head;
          void'(fl_q.pop_front());
          cq.push_back('{in_rd_a, fl_head});
        end else begin
          m_rd = '0; m_old = '0; m_we = 1'b0;
        end
        m_ov = 1'b1;
      end else if (!out_stall) begin
        m_ov = 1'b0;
      end
      m_rrat = nrrat;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_rs1_p", out_rs1_p, m_rs1);
    check("out_rs2_p", out_rs2_p, m_rs2);
    check("out_rd_p", out_rd_p, m_rd);
    check("out_old_rd_p", out_old_rd_p, m_old);
    check("out_rd_we", out_rd_we, m_we);
  endtask

  initial begin
    model_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    idle();
    check("reset_out_valid", out_valid, 0);

    // add x3,x1,x2 with head tag 40
    put_front(6'd40);
    ren(1, 2, 3, 1'b1); step();
    check("add_rs1", out_rs1_p, 1);
    check("add_rs2", out_rs2_p, 2);
    check("add_rd", out_rd_p, 40);
    check("add_old", out_old_rd_p, 3);
    check("add_pop", obs_pop, 1);
    idle(); step();
    check("add_pop_off", obs_pop, 0);

    // x5 <= x5 twice, back to back
    put_front(6'd34); put_front(6'd33);
    ren(5, 0, 5, 1'b1); step();
    check("x5a_rs1", out_rs1_p, 5);
    check("x5a_rd", out_rd_p, 33);
    step();
    check("x5b_rs1", out_rs1_p, 33);
    check("x5b_rd", out_rd_p, 34);
    check("x5b_old", out_old_rd_p, 33);

    // x0 destination
    ren(0, 0, 0, 1'b1); step();
    check("x0_rd", out_rd_p, 0);
    check("x0_we", out_rd_we, 0);
    check("x0_pop", obs_pop, 0);

    // empty free list blocks writers only
    fl_block = 1'b1;
    ren(1, 1, 4, 1'b1); step();
    check("empty_ready", obs_ready, 0);
    check("empty_pop", obs_pop, 0);
    ren(1, 1, 4, 1'b0); step();
    check("empty_nowrite_ready", obs_ready, 1);
    check("empty_nowrite_valid", out_valid, 1);
    idle();

    // output stall for three cycles
    ren(2, 3, 6, 1'b1); step();
    out_stall = 1'b1;
    ren(6, 0, 6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_ready", obs_ready, 0);
    end
    out_stall = 1'b0; step();
    check("release_ready", obs_ready, 1);
    check("release_rs1", out_rs1_p, m_rat[6]);
    idle();

    // rename x7 -> 45 then retire in order up to it
    put_front(6'd45);
    ren(0, 0, 7, 1'b1); step();
    idle();
    while (cq.size() > 0 && cq[0].a != 5'd7) begin
      idle(); commit_head(); step();
    end
    idle(); commit_head(); step();
    check("commit7_push", obs_push, 1);
    check("commit7_data", obs_fdata, 7);

    // speculative x7 -> 46 discarded by flush
    idle(); put_front(6'd46);
    ren(0, 0, 7, 1'b1); step();
    idle(); flush = 1'b1; step();
    idle(); ren(7, 0, 0, 1'b0); step();
    check("flush_x7", out_rs1_p, 45);

    // flush with same-cycle commit of x9 -> 50
    idle(); put_front(6'd50);
    ren(0, 0, 9, 1'b1); step();
    idle(); flush = 1'b1; commit_head(); ren(9, 9, 2, 1'b1); step();
    check("fc_push", obs_push, 1);
    check("fc_data", obs_fdata, 9);
    check("fc_pop", obs_pop, 0);
    check("fc_valid", out_valid, 0);
    idle(); ren(9, 0, 0, 1'b0); step();
    check("fc_x9", out_rs1_p, 50);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs1_a  = 5'($urandom_range(0, 31));
      in_rs2_a  = 5'($urandom_range(0, 31));
      in_rd_a   = 5'($urandom_range(0, 31));
      in_rd_we  = ($urandom_range(0, 3) != 0);
      fl_block  = ($urandom_range(0, 9) == 0);
      out_stall = ($urandom_range(0, 3) == 0);
      if (cq.size() > 0 && $urandom_range(0, 2) != 0) commit_head();
      else if ($urandom_range(0, 9) == 0) begin
        commit_valid = 1'b1;
        commit_rd_a  = '0;
        commit_rd_p  = PB'($urandom_range(0, (1 << PB) - 1));
      end
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rename_rat.md
# rename_rat

Register-rename stage between decode and dispatch. It maps architectural registers to physical registers through a speculative rename table (RAT) and allocates a destination tag from the PRF free list each cycle. It keeps a retirement RAT (RRAT) that commit updates, and returns each superseded physical tag to the free list. On flush it restores the speculative map from the RRAT. Throughput is one instruction per cycle, with one registered output stage feeding dispatch and the PRF read ports.

## Interface
- PHYS_REG_BITS, 6, physical tag width (2**PHYS_REG_BITS physical regs; at least 6)
- ARCH_REGS, 32, architectural registers (5-bit index)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- in_valid  in  1  decoded instruction present
- in_ready  out  1  rename accepts instruction this cycle
- in_rs1_a, in_rs2_a, in_rd_a  in  5 each  architectural source/dest indices
- in_rd_we  in  1  instruction writes a destination
- fl_avail  in  1  free list non-empty
- fl_head  in  PHYS_REG_BITS  free tag at free-list head (valid when fl_avail)
- fl_pop  out  1  consume fl_head this cycle
- out_valid  out  1  renamed instruction held in output register
- out_stall  in  1  downstream cannot take output
- out_rs1_p, out_rs2_p, out_rd_p, out_old_rd_p  out  PHYS_REG_BITS each  renamed tags; old_rd_p is the prior mapping of rd
- out_rd_we  out  1  renamed instruction allocated a tag
- commit_valid  in  1  instruction retiring
- commit_rd_a  in  5  retiring architectural dest
- commit_rd_p  in  PHYS_REG_BITS  retiring physical dest
- free_push  out  1  return free_data to free list
- free_data  out  PHYS_REG_BITS  tag being freed
- flush  in  1  mispredict / exception recovery

## Operation
- Definitions:
  - fire = in_valid & in_ready.
  - alloc = fire & in_rd_we & (in_rd_a != 0).
- in_ready = ~flush & (~out_valid | ~out_stall) & (fl_avail | ~in_rd_we | in_rd_a == 0). It is combinational.
- Source lookup is a combinational RAT read at fire: out_rs1_p = RAT[in_rs1_a] and out_rs2_p = RAT[in_rs2_a]. These are registered into the output stage.
- x0 is never renamed: RAT[0] and RRAT[0] are permanently 0 (writes are ignored).
  - rd_a == 0 gives no pop, out_rd_p = 0, out_old_rd_p = 0, out_rd_we = 0.
- On alloc:
  - fl_pop = 1 (combinational, same cycle).
  - out_rd_p <= fl_head.
  - out_old_rd_p <= RAT[in_rd_a].
  - RAT[in_rd_a] <= fl_head.
- Sources read the RAT before the same instruction's rd update. For example, "add x5,x5,x1" gets the old x5 tag.
- A following instruction sees the update with no bypass needed, because the write lands at the clock edge.
- On commit (commit_valid & commit_rd_a != 0), in the same cycle:
  - free_push = 1, free_data = RRAT[commit_rd_a] (combinational);
  - RRAT[commit_rd_a] <= commit_rd_p.
- Commit with rd_a == 0: free_push = 0 and the RRAT is unchanged.
- Flush:
  - RAT[i] <= next RRAT value, including a commit in the same cycle.
  - out_valid <= 0, fl_pop = 0, in_ready = 0.
  - Flush takes priority over fire.
  - Commit-side freeing still occurs during flush.
- Output stage: loads on fire. When ~fire & ~out_stall, out_valid <= 0. When out_stall & out_valid, all outputs hold.
- Initial map at reset: RAT[i] = RRAT[i] = i. The free list must therefore hold tags 32..2**PHYS_REG_BITS-1.

## Timing
- Reset values:
  - out_valid = 0.
  - out_rs1_p, out_rs2_p, out_rd_p, out_old_rd_p = 0; out_rd_we = 0.
  - RAT and RRAT identity.
  - fl_pop = free_push = 0 while rst is high; in_ready = 0 during rst.
- Latency: one cycle from fire to out_valid.
- fl_pop is asserted only in a cycle where fire occurs, never speculatively.
- The free list is empty (fl_avail = 0) with in_rd_we & rd_a != 0: in_ready = 0 and there is no pop. A non-writing instruction still proceeds.
- Commit and alloc in the same cycle:
  - They touch different tables, so both take effect.
  - free_push and fl_pop may both be high. The free list handles simultaneous push/pop.
- Commit and flush in the same cycle: the restored RAT entry equals commit_rd_p for commit_rd_a.
- rst asserted mid-operation: all state returns to reset values on the next edge. In-flight output is discarded.

## Test plan
- Reset, then rename "add x3,x1,x2" with fl_head = 40 -> next cycle: out_rs1_p = 1, out_rs2_p = 2, out_rd_p = 40, out_old_rd_p = 3, fl_pop pulsed 1 cycle.
- Back-to-back "x5 <= x5" twice with fl_head 33 then 34:
  - first: rs1_p = 5, rd_p = 33;
  - second: rs1_p = 33, rd_p = 34, old_rd_p = 33.
- rd = x0 and sources = x0 -> all tags 0, fl_pop = 0, out_rd_we = 0. fl_avail = 0 with rd = x4 -> in_ready = 0, no pop; a non-writing instruction is still accepted.
- out_stall held 3 cycles with out_valid = 1 -> outputs stable, in_ready = 0, no RAT change. On release the next instruction fires.
- Rename x7 -> 45, commit (x7, 45) -> free_push = 1, free_data = 7, and RRAT[7] = 45.
- Rename x7 -> 46, then flush -> next rename reading x7 gets 45.
- Flush in the same cycle as commit (x9, 50) -> RAT[9] = 50, out_valid = 0, fl_pop = 0, free_push = 1 with free_data = 9.
